// File: rtl/drawbridge_ctrl.sv
// Drawbridge sequencer: warns traffic, closes the barrier, drives the span counter, watches for stalls.
// Moore outputs, one cycle from any input; no backpressure, requests are levels sampled every clock.
module drawbridge_ctrl #(
  parameter int POS_W        = 8,
  parameter int POS_MAX      = 200,
  parameter int LAG          = 2,
  parameter int WARN_CYCLES  = 16,
  parameter int STALL_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raise_req,
  input  logic             lower_req,
  input  logic             estop,
  input  logic [POS_W-1:0] pos,
  output logic             up,
  output logic             down,
  output logic             gate_closed,
  output logic             warn,
  output logic [2:0]       state,
  output logic             fault
);

  localparam int TMR_W = (WARN_CYCLES > 2) ? $clog2(WARN_CYCLES) : 1;
  localparam int STL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES + 1) : 1;

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WARN_CYCLES - 1);
  localparam logic [STL_W-1:0] STL_LIM  = STL_W'(STALL_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_HI   = POS_W'(POS_MAX - LAG);
  localparam logic [POS_W-1:0] POS_LO   = POS_W'(LAG);

  typedef enum logic [2:0] {
    S_DOWN     = 3'd0,
    S_WARN     = 3'd1,
    S_RAISING  = 3'd2,
    S_OPEN     = 3'd3,
    S_LOWERING = 3'd4,
    S_CLEAR    = 3'd5,
    S_ESTOP    = 3'd6,
    S_FAULT    = 3'd7
  } st_t;

  st_t              st_q, st_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [STL_W-1:0] stl_q, stl_d;
  logic [POS_W-1:0] prev_q;
  logic             moving, stalled, stall_trip;

  assign moving     = (st_q == S_RAISING) || (st_q == S_LOWERING);
  assign stalled    = (pos == prev_q);
  // The cycle that would push the stall count to its limit is the one that trips.
  assign stall_trip = moving && stalled && (stl_q >= STL_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_DOWN;
      tmr_q  <= '0;
      stl_q  <= '0;
      prev_q <= '0;
    end else begin
      st_q   <= st_d;
      tmr_q  <= tmr_d;
      stl_q  <= stl_d;
      prev_q <= pos;
    end
  end

  always_comb begin
    st_d  = st_q;
    tmr_d = (tmr_q != '0) ? tmr_q - 1'b1 : '0;
    if (st_q != S_FAULT && estop) begin
      st_d = S_ESTOP;
    end else if (stall_trip) begin
      st_d = S_FAULT;
    end else begin
      case (st_q)
        S_DOWN: if (raise_req) begin
          st_d  = S_WARN;
          tmr_d = TMR_LOAD;
        end
        S_WARN: if (tmr_q == '0) st_d = S_RAISING;
        S_RAISING: begin
          if (pos >= POS_HI)                st_d = S_OPEN;
          else if (lower_req && !raise_req) st_d = S_LOWERING;
        end
        S_OPEN: if (lower_req && !raise_req) st_d = S_LOWERING;
        S_LOWERING: begin
          if (pos <= POS_LO) begin
            st_d  = S_CLEAR;
            tmr_d = TMR_LOAD;
          end else if (raise_req) begin
            st_d = S_RAISING;
          end
        end
        S_CLEAR: begin
          if (raise_req)          st_d = S_RAISING;
          else if (tmr_q == '0)   st_d = S_DOWN;
        end
        S_ESTOP: if (!raise_req && !lower_req) begin
          if (pos <= POS_LO) begin
            st_d  = S_CLEAR;
            tmr_d = TMR_LOAD;
          end else begin
            st_d = S_LOWERING;
          end
        end
        S_FAULT: st_d = S_FAULT;
        default: st_d = S_DOWN;
      endcase
    end
    // Stall count only survives while staying in a motion state with a frozen position.
    stl_d = '0;
    if (moving && (st_d == st_q) && stalled)
      stl_d = (stl_q == '1) ? stl_q : stl_q + 1'b1;
  end

  always_comb begin
    up          = (st_q == S_RAISING);
    down        = (st_q == S_LOWERING);
    gate_closed = (st_q != S_DOWN);
    warn        = (st_q == S_WARN) || (st_q == S_RAISING) || (st_q == S_LOWERING) ||
                  (st_q == S_CLEAR) || (st_q == S_ESTOP);
    fault       = (st_q == S_FAULT);
    state       = st_q;
  end

endmodule

// File: doc/drawbridge_ctrl.md
DRAWBRIDGE_CTRL -- requirements
Module: drawbridge_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- POS_W, 8, position width.
- POS_MAX, 200, fully-raised position.
- LAG, 2, counter pipeline allowance in position units.
- WARN_CYCLES, 16, warning dwell in clocks.
- STALL_CYCLES, 64, motion watchdog limit in clocks.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 raise_req  input  1  level request to open the bridge.
REQ-005 lower_req  input  1  level request to close the bridge.
REQ-006 estop  input  1  emergency stop, level-sensitive.
REQ-007 pos  input  POS_W  current position from the up/down position counter; 0 = down.
REQ-008 up  output  1  drives the counter's up input.
REQ-009 down  output  1  drives the counter's down input.
REQ-010 gate_closed  output  1  road barrier lowered.
REQ-011 warn  output  1  traffic warning light.
REQ-012 state  output  3  encoded FSM state per REQ-014.
REQ-013 fault  output  1  sticky watchdog fault.

Function
REQ-014 FSM SHALL have states DOWN=0, WARN=1, RAISING=2, OPEN=3, LOWERING=4, CLEAR=5, ESTOP=6, FAULT=7, held in a register.
REQ-015 All outputs SHALL be decoded from the registered state only (Moore), so pos and request inputs have one cycle of latency to any output.
REQ-016 Output decode SHALL be:
- up=1 only in RAISING; down=1 only in LOWERING; up and down never both 1.
- gate_closed=1 in every state except DOWN.
- warn=1 in WARN, RAISING, LOWERING, CLEAR and ESTOP.
- fault=1 only in FAULT.
REQ-017 Transitions from DOWN SHALL be: raise_req -> WARN, loading the dwell timer with WARN_CYCLES-1.
REQ-018 Transitions from WARN SHALL be: timer decrements each cycle; at 0 -> RAISING. WARN SHALL last exactly WARN_CYCLES cycles.
REQ-019 Transitions from RAISING SHALL be:
- pos >= POS_MAX-LAG -> OPEN.
- Otherwise lower_req=1 and raise_req=0 -> LOWERING (direct reversal).
REQ-020 Transitions from OPEN SHALL be: lower_req=1 and raise_req=0 -> LOWERING; raise_req ignored.
REQ-021 Transitions from LOWERING SHALL be:
- pos <= LAG -> CLEAR, loading the timer with WARN_CYCLES-1.
- Otherwise raise_req=1 -> RAISING (raise has priority over lower).
REQ-022 Transitions from CLEAR SHALL be: raise_req -> RAISING (barrier already closed); otherwise timer at 0 -> DOWN. CLEAR SHALL last WARN_CYCLES cycles when not interrupted.
REQ-023 Request priority SHALL be: with raise_req and lower_req both high in DOWN, raise wins; in OPEN, the bridge stays OPEN.
REQ-024 estop=1 in any state except FAULT SHALL force ESTOP on the next edge, overriding all other transitions.
REQ-025 Exit from ESTOP SHALL occur only on a cycle with estop=0, raise_req=0 and lower_req=0:
- pos <= LAG -> CLEAR, loading the timer.
- Otherwise -> LOWERING.
REQ-026 Motion watchdog: in RAISING or LOWERING, a stall counter SHALL increment each cycle pos equals its previous-cycle value and clear on any change or on state entry.
REQ-027 When the stall counter reaches STALL_CYCLES, the FSM SHALL enter FAULT.
REQ-028 FAULT SHALL be exited only by rst_n.
REQ-029 The timer and stall counter SHALL be sized with $clog2 of their limits (minimum 1 bit) and SHALL saturate, never wrap.
REQ-030 Comparisons against pos SHALL be unsigned at POS_W bits; POS_MAX-LAG and LAG SHALL be constants.

Reset
REQ-031 rst_n=0 SHALL immediately set state=DOWN, timer=0, stall counter=0 and the previous-pos register=0.
REQ-032 Reset outputs SHALL be up=0, down=0, gate_closed=0, warn=0, fault=0, state=0.
REQ-033 Reset asserted mid-motion SHALL drop up and down asynchronously, without waiting for a clock.
REQ-034 After rst_n deasserts, the first transition SHALL occur on the first rising clk edge.

Verification (bench params: POS_MAX=20, LAG=2, WARN_CYCLES=4, STALL_CYCLES=8; counter model updates pos 2 cycles after up/down)
REQ-035 Full cycle: raise_req pulse from DOWN -> 4 WARN cycles, RAISING until pos>=18, then OPEN with up=0; lower_req -> LOWERING until pos<=2, 4 CLEAR cycles, DOWN with gate_closed=0.
REQ-036 Reversal: lower_req at pos=10 during RAISING -> LOWERING next edge, up=0 and down=1 with no overlap cycle; raise_req at pos=6 -> RAISING.
REQ-037 E-stop: estop at pos=12 in RAISING -> ESTOP, up=down=0, warn=1. Release with no requests -> LOWERING -> CLEAR -> DOWN.
REQ-038 Watchdog: pos frozen at 7 in RAISING -> FAULT after 8 stalled cycles, fault=1. FAULT persists through estop and requests until rst_n.
REQ-039 Priority: raise_req and lower_req both high in DOWN -> WARN; both high in OPEN -> stays OPEN; raise_req during CLEAR -> RAISING, skipping WARN.
REQ-040 Async reset: rst_n low between edges while in LOWERING -> up=down=0 and state=0 before the next clk edge.
